mioc_flop_array: RTL and testbench

MIOC_FLOP_ARRAY -- requirements
Module: mioc_flop_array

---
 rtl/mioc_flop_array.sv | 132 +++++++++++++
 tb/tb_mioc_flop_array.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_flop_array.sv
// Purpose : array of independent set/clear/toggle/load flops with optional auto-clearing pulse mode.
// Latency : set/clr/tog -> q in SYNC_STAGES+1 cycles; load/d -> q in 1 cycle.
// Backpres: none; level requests act on every cycle they are seen and cannot be stalled.
//
// Ports:
//   clk, rst          sole clock (rising edge); asynchronous active-high reset
//   set, clr, tog     per-channel level requests, asynchronous to clk, synchronized internally
//   d, load           parallel load data and strobe, synchronous to clk
//   pmode             per-channel mode: 1 = pulse (auto-clear after PULSE_LEN cycles), 0 = sticky
//   q, qbar           registered state and its combinational complement
//   rise, fall        registered one-cycle edge markers aligned with q
//   conflict          registered pulse: some channel saw synchronized set and clr together
module mioc_flop_array #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] tog,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic [WIDTH-1:0] pmode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             conflict
);

    localparam int            CW     = $clog2(PULSE_LEN + 1);
    // Counter is reloaded with PULSE_LEN-1 so that the values PULSE_LEN-1..0
    // span exactly PULSE_LEN high cycles; expiry happens on the zero cycle.
    localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] sc;
    logic [WIDTH-1:0] st;

    // ---------------------------------------------------------------
    // Request synchronizers (bypassed entirely when SYNC_STAGES == 0)
    // ---------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ss = set;
            assign sc = clr;
            assign st = tog;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] set_pipe;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] clr_pipe;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] tog_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    set_pipe <= '0;
                    clr_pipe <= '0;
                    tog_pipe <= '0;
                end else begin
                    set_pipe[0] <= set;
                    clr_pipe[0] <= clr;
                    tog_pipe[0] <= tog;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        set_pipe[s] <= set_pipe[s-1];
                        clr_pipe[s] <= clr_pipe[s-1];
                        tog_pipe[s] <= tog_pipe[s-1];
                    end
                end
            end

            assign ss = set_pipe[SYNC_STAGES-1];
            assign sc = clr_pipe[SYNC_STAGES-1];
            assign st = tog_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Next-state and pulse counters
    // ---------------------------------------------------------------
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0][CW-1:0] cnt_nxt;
    logic [WIDTH-1:0]         q_nxt;
    logic [WIDTH-1:0]         trig;
    logic [WIDTH-1:0]         expire;

    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        trig    = '0;
        expire  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            expire[i] = q[i] && pmode[i] && (cnt[i] == '0);

            if (sc[i])         q_nxt[i] = 1'b0;
            else if (ss[i])    q_nxt[i] = 1'b1;
            else if (load)     q_nxt[i] = d[i];
            else if (st[i])    q_nxt[i] = ~q[i];
            else if (expire[i]) q_nxt[i] = 1'b0;

            // A set/load/tog that leaves the channel high (re)starts the pulse,
            // including when the channel is already high.
            trig[i] = q_nxt[i] && (ss[i] || load || st[i]);

            if (trig[i] && pmode[i])
                cnt_nxt[i] = RELOAD;
            else if (q[i] && pmode[i] && (cnt[i] != '0))
                cnt_nxt[i] = cnt[i] - ONE;
            // pmode low: counter frozen so a later re-enable resumes the countdown
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= '0;
            rise     <= '0;
            fall     <= '0;
            conflict <= 1'b0;
            cnt      <= '0;
        end else begin
            q        <= q_nxt;
            rise     <= q_nxt & ~q;
            fall     <= ~q_nxt & q;
            conflict <= |(ss & sc);
            cnt      <= cnt_nxt;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_mioc_flop_array.sv
module tb_mioc_flop_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] set = '0, clr = '0, tog = '0, d = '0, pmode = '0;
    logic       load = 1'b0;
    logic [3:0] q, qbar, rise, fall;
    logic       conflict;

    // Second build: no synchronizer, single-cycle pulse
    logic [3:0] set2 = '0, pmode2 = '0;
    logic [3:0] zero4 = '0;
    logic [3:0] q2, qbar2, rise2, fall2;
    logic       conflict2;

    mioc_flop_array #(.WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(8)) dut (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .tog(tog), .d(d),
        .load(load), .pmode(pmode), .q(q), .qbar(qbar), .rise(rise),
        .fall(fall), .conflict(conflict)
    );

    mioc_flop_array #(.WIDTH(4), .SYNC_STAGES(0), .PULSE_LEN(1)) dut2 (
        .clk(clk), .rst(rst), .set(set2), .clr(zero4), .tog(zero4), .d(zero4),
        .load(1'b0), .pmode(pmode2), .q(q2), .qbar(qbar2), .rise(rise2),
        .fall(fall2), .conflict(conflict2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       conf;
        string      name;
    } exp_t;

    exp_t sb[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input int id, input logic [3:0] eq,
                             input logic [3:0] er, input logic [3:0] ef,
                             input logic ec, input string name);
        exp_t e;
        e.cyc = cyc + dc; e.id = id; e.q = eq; e.rise = er; e.fall = ef;
        e.conf = ec; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_reset_now(input string name);
        checks++;
        if (q !== 4'b0 || qbar !== 4'hF || rise !== 4'b0 || fall !== 4'b0 || conflict !== 1'b0 ||
            q2 !== 4'b0 || qbar2 !== 4'hF || rise2 !== 4'b0 || fall2 !== 4'b0 || conflict2 !== 1'b0) begin
            failures++;
            $display("FAIL %s: got q=%b qbar=%b rise=%b fall=%b conf=%b q2=%b qbar2=%b, required q=0 qbar=1111 rise=0 fall=0 conf=0",
                     name, q, qbar, rise, fall, conflict, q2, qbar2);
        end
    endtask

    // Monitor: compare every queued expectation in the cycle it targets
    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].cyc == cyc) begin
                logic [3:0] aq, ab, ar, af;
                logic       ac;
                if (sb[i].id == 0) begin
                    aq = q; ab = qbar; ar = rise; af = fall; ac = conflict;
                end else begin
                    aq = q2; ab = qbar2; ar = rise2; af = fall2; ac = conflict2;
                end
                checks++;
                if (aq !== sb[i].q || ab !== ~sb[i].q || ar !== sb[i].rise ||
                    af !== sb[i].fall || ac !== sb[i].conf) begin
                    failures++;
                    $display("FAIL %s @cyc %0d dut%0d: got q=%b qbar=%b rise=%b fall=%b conf=%b, required q=%b qbar=%b rise=%b fall=%b conf=%b",
                             sb[i].name, cyc, sb[i].id, aq, ab, ar, af, ac,
                             sb[i].q, ~sb[i].q, sb[i].rise, sb[i].fall, sb[i].conf);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cyc %0d never compared (now %0d)", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        // ---- reset state ----
        #1 rst = 1'b1;
        #2 check_reset_now("reset_state");
        tick(3);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            expect_at(k, 0, 4'b0, 4'b0, 4'b0, 1'b0, "post_release");
            expect_at(k, 1, 4'b0, 4'b0, 4'b0, 1'b0, "post_release2");
        end
        tick(4);

        // ---- sticky set then clear, 3-cycle latency ----
        set = 4'b0001;
        expect_at(1, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "set_lat1");
        expect_at(2, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "set_lat2");
        expect_at(3, 0, 4'b0001, 4'b0001, 4'b0, 1'b0, "set_rise");
        expect_at(4, 0, 4'b0001, 4'b0, 4'b0, 1'b0, "set_hold1");
        expect_at(5, 0, 4'b0001, 4'b0, 4'b0, 1'b0, "set_hold2");
        tick(1); set = 4'b0;
        tick(5);
        clr = 4'b0001;
        expect_at(2, 0, 4'b0001, 4'b0, 4'b0, 1'b0, "clr_lat");
        expect_at(3, 0, 4'b0000, 4'b0, 4'b0001, 1'b0, "clr_fall");
        expect_at(4, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "clr_hold");
        tick(1); clr = 4'b0;
        tick(5);

        // ---- pulse mode: exactly 8 high cycles ----
        pmode = 4'b0010;
        set   = 4'b0010;
        for (int k = 2; k <= 12; k++)
            expect_at(k, 0, (k >= 3 && k <= 10) ? 4'b0010 : 4'b0000,
                      (k == 3) ? 4'b0010 : 4'b0000, (k == 11) ? 4'b0010 : 4'b0000, 1'b0, "pulse8");
        tick(1); set = 4'b0;
        tick(13);

        // ---- retrigger at high-cycle 5: 13 high cycles, one rise, one fall ----
        set = 4'b0010;
        for (int k = 2; k <= 17; k++)
            expect_at(k, 0, (k >= 3 && k <= 15) ? 4'b0010 : 4'b0000,
                      (k == 3) ? 4'b0010 : 4'b0000, (k == 16) ? 4'b0010 : 4'b0000, 1'b0, "retrigger");
        tick(1); set = 4'b0;
        tick(4); set = 4'b0010;
        tick(1); set = 4'b0;
        tick(13);
        pmode = 4'b0;

        // ---- set/clr conflict on channel 2 ----
        set = 4'b0100;
        expect_at(3, 0, 4'b0100, 4'b0100, 4'b0, 1'b0, "pre_conflict_set");
        tick(1); set = 4'b0;
        tick(5);
        set = 4'b0100; clr = 4'b0100;
        expect_at(2, 0, 4'b0100, 4'b0, 4'b0, 1'b0, "conflict_lat");
        expect_at(3, 0, 4'b0000, 4'b0, 4'b0100, 1'b1, "conflict_hit");
        expect_at(4, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "conflict_once");
        tick(1); set = 4'b0; clr = 4'b0;
        tick(5);

        // ---- pmode dropped mid-pulse freezes, re-enable resumes (14 high cycles) ----
        pmode = 4'b0100;
        set   = 4'b0100;
        for (int k = 2; k <= 18; k++)
            expect_at(k, 0, (k >= 3 && k <= 16) ? 4'b0100 : 4'b0000,
                      (k == 3) ? 4'b0100 : 4'b0000, (k == 17) ? 4'b0100 : 4'b0000, 1'b0, "freeze");
        tick(1); set = 4'b0;
        tick(3); pmode = 4'b0;
        tick(6); pmode = 4'b0100;
        tick(9);
        pmode = 4'b0;

        // ---- load beats toggle, then held toggle oscillates ----
        tog = 4'b1111;
        expect_at(1, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "tog_lat1");
        expect_at(2, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "tog_lat2");
        tick(2);
        load = 1'b1; d = 4'b1010;
        expect_at(1, 0, 4'b1010, 4'b1010, 4'b0000, 1'b0, "load_beats_tog");
        expect_at(2, 0, 4'b0101, 4'b0101, 4'b1010, 1'b0, "tog_osc1");
        expect_at(3, 0, 4'b1010, 4'b1010, 4'b0101, 1'b0, "tog_osc2");
        expect_at(4, 0, 4'b0101, 4'b0101, 4'b1010, 1'b0, "tog_osc3");
        tick(1); load = 1'b0; d = 4'b0;
        tick(3); tog = 4'b0;
        tick(5);
        rst = 1'b1;
        tick(1); rst = 1'b0;
        tick(4);

        // ---- reset mid-pulse, then request held through reset ----
        pmode = 4'b1000;
        set   = 4'b1000;
        expect_at(1, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "rstp_lat1");
        expect_at(2, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "rstp_lat2");
        for (int k = 3; k <= 6; k++)
            expect_at(k, 0, 4'b1000, (k == 3) ? 4'b1000 : 4'b0000, 4'b0, 1'b0, "rstp_high");
        tick(1); set = 4'b0;
        tick(6);
        rst = 1'b1; set = 4'b0001;
        #1 check_reset_now("reset_mid_pulse");
        expect_at(0, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "rst_no_fall");
        tick(2);
        rst = 1'b0;
        expect_at(1, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "resync1");
        expect_at(2, 0, 4'b0000, 4'b0, 4'b0, 1'b0, "resync2");
        expect_at(3, 0, 4'b0001, 4'b0001, 4'b0, 1'b0, "resync_set");
        expect_at(4, 0, 4'b0001, 4'b0, 4'b0, 1'b0, "resync_hold");
        tick(1); set = 4'b0;
        tick(6);
        pmode = 4'b0;

        // ---- no-sync build: 1-cycle latency, PULSE_LEN=1 gives single-cycle pulse ----
        set2 = 4'b0001; pmode2 = 4'b0001;
        expect_at(1, 1, 4'b0001, 4'b0001, 4'b0, 1'b0, "nosync_lat");
        expect_at(2, 1, 4'b0000, 4'b0, 4'b0001, 1'b0, "pulse1_end");
        expect_at(3, 1, 4'b0000, 4'b0, 4'b0, 1'b0, "pulse1_idle");
        tick(1); set2 = 4'b0;
        tick(4);
        set2 = 4'b0010;
        expect_at(1, 1, 4'b0011 & 4'b0010, 4'b0010, 4'b0, 1'b0, "nosync_sticky");
        expect_at(2, 1, 4'b0010, 4'b0, 4'b0, 1'b0, "nosync_sticky_hold");
        tick(1); set2 = 4'b0;
        tick(3);

        // drain scoreboard with a bounded wait
        for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
